vga_board_adapter: RTL and testbench

- Board-side bridge between the 25 MHz core video output and a narrow-DAC VGA connector.
- Reduces CHANNELS colour channels from IN_W to OUT_W bits per channel.
- Reduction modes are runtime-selectable: truncate, round, or ordered 2x2/4x4 Bayer dither, with optional temporal dither.
- Also generates a stretched core reset from the clock-wizard LOCKED signal.
- Sits between the clock wizard / core top entity and the board pins.

---
 rtl/vga_board_adapter.sv | 182 ++++++++++++++++++
 tb/tb_vga_board_adapter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_board_adapter.sv
// vga_board_adapter
// Bridges the 25 MHz core video output to a narrow-DAC VGA connector and
// produces the stretched core reset from the clock-wizard lock.
//
// Colour path: two register stages. Stage 1 captures pixel and syncs and
// detects sync assertions. Stage 2 reduces each channel from IN_W to OUT_W
// bits using truncate / round / Bayer 2x2 / Bayer 4x4, and registers the
// result together with the delayed syncs, so colour and syncs stay aligned
// at two cycles of latency.
//
// Ports:
//   i_clk_25mhz    pixel clock, the only clock
//   i_reset        synchronous active-high reset, clears all state
//   i_locked       clock-wizard lock
//   i_mode         0 truncate, 1 round, 2 Bayer 2x2, 3 Bayer 4x4
//   i_hsync_in     core horizontal sync (active level SYNC_ACTIVE)
//   i_vsync_in     core vertical sync (active level SYNC_ACTIVE)
//   i_pix_in       core colour, channel 0 in the LSBs
//   o_hsync_out    horizontal sync delayed by two cycles
//   o_vsync_out    vertical sync delayed by two cycles
//   o_pix_out      reduced colour, channel 0 in the LSBs
//   o_core_reset   active-high reset to the core
module vga_board_adapter #(
  parameter int CHANNELS    = 3,
  parameter int IN_W        = 8,
  parameter int OUT_W       = 4,
  parameter int SYNC_ACTIVE = 0,
  parameter int TEMPORAL    = 0,
  parameter int RESET_HOLD  = 16,
  parameter int X_W         = 11,
  parameter int Y_W         = 10
) (
  input  logic                      i_clk_25mhz,
  input  logic                      i_reset,
  input  logic                      i_locked,
  input  logic [1:0]                i_mode,
  input  logic                      i_hsync_in,
  input  logic                      i_vsync_in,
  input  logic [CHANNELS*IN_W-1:0]  i_pix_in,
  output logic                      o_hsync_out,
  output logic                      o_vsync_out,
  output logic [CHANNELS*OUT_W-1:0] o_pix_out,
  output logic                      o_core_reset
);

  localparam int   DROP     = IN_W - OUT_W;
  // The 4-bit pattern value is scaled to the dropped LSB range.
  localparam int   SHL      = (DROP >= 4) ? DROP - 4 : 0;
  localparam int   SHR      = (DROP >= 4) ? 0 : 4 - DROP;
  localparam int   CW       = $clog2(RESET_HOLD + 1);
  localparam logic SYNC_ON  = 1'(SYNC_ACTIVE);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [CHANNELS*IN_W-1:0]  r_pix1;
  logic                      r_hs1;
  logic                      r_vs1;
  logic                      r_hs2;
  logic                      r_vs2;
  logic [CHANNELS*OUT_W-1:0] r_pix2;
  logic [X_W-1:0]            r_x;
  logic [Y_W-1:0]            r_y;
  logic [1:0]                r_f;
  logic [1:0]                r_mode;
  logic [CW-1:0]             r_cnt;
  logic                      r_core_reset;

  logic                      w_h_edge;
  logic                      w_v_edge;
  logic [1:0]                w_xi;
  logic [1:0]                w_yi;
  logic [3:0]                w_b;
  logic [IN_W:0]             w_thr;
  logic [CHANNELS*OUT_W-1:0] w_red;

  function automatic logic [3:0] bayer4(input logic [1:0] yi, input logic [1:0] xi);
    logic [3:0] v;
    case ({yi, xi})
      4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
      4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
      4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'ha: v = 4'd1;   4'hb: v = 4'd9;
      4'hc: v = 4'd15;  4'hd: v = 4'd7;   4'he: v = 4'd13;  default: v = 4'd5;
    endcase
    return v;
  endfunction

  // The stage-2 register holds the previous stage-1 sync, so it doubles as
  // the history bit for assertion detection.
  assign w_h_edge = (r_hs1 == SYNC_ON) && (r_hs2 != SYNC_ON);
  assign w_v_edge = (r_vs1 == SYNC_ON) && (r_vs2 != SYNC_ON);

  // Counters, mode and frame are used as registered, so the pixel that
  // coincides with a sync assertion still belongs to the old line/frame and
  // the following pixel is the first one at x = 0 / new mode.
  always_comb begin
    w_xi = r_x[1:0];
    w_yi = r_y[1:0];
    if (TEMPORAL != 0) begin
      w_xi = w_xi ^ {r_f[1], r_f[0]};
      w_yi = w_yi ^ {r_f[0], r_f[1]};
    end
  end

  always_comb begin
    w_b = 4'd0;
    case (r_mode)
      2'd0: w_b = 4'd0;
      2'd1: w_b = 4'd8;
      2'd2: begin
        case ({w_yi[0], w_xi[0]})
          2'b00:   w_b = 4'd0;
          2'b01:   w_b = 4'd8;
          2'b10:   w_b = 4'd12;
          default: w_b = 4'd4;
        endcase
      end
      default: w_b = bayer4(w_yi, w_xi);
    endcase
  end

  assign w_thr = (IN_W + 1)'(({{(IN_W + 1){1'b0}}, w_b} << SHL) >> SHR);

  always_comb begin
    logic [IN_W:0]   sum;
    logic [IN_W-1:0] sat;
    w_red = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum = {1'b0, r_pix1[c*IN_W +: IN_W]} + w_thr;
      sat = sum[IN_W] ? {IN_W{1'b1}} : sum[IN_W-1:0];
      w_red[c*OUT_W +: OUT_W] = OUT_W'(sat >> DROP);
    end
  end

  always_ff @(posedge i_clk_25mhz) begin
    if (i_reset) begin
      r_pix1 <= '0;
      r_hs1  <= SYNC_OFF;
      r_vs1  <= SYNC_OFF;
      r_hs2  <= SYNC_OFF;
      r_vs2  <= SYNC_OFF;
      r_pix2 <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_f    <= '0;
      r_mode <= '0;
    end else begin
      r_pix1 <= i_pix_in;
      r_hs1  <= i_hsync_in;
      r_vs1  <= i_vsync_in;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_pix2 <= w_red;
      r_x    <= w_h_edge ? '0 : r_x + X_W'(1);
      if (w_v_edge) begin
        r_y    <= '0;
        r_f    <= r_f + 2'd1;
        r_mode <= i_mode;
      end else if (w_h_edge) begin
        r_y <= r_y + Y_W'(1);
      end
    end
  end

  // Down-counter from RESET_HOLD; the core is released on the edge after
  // the count reaches zero, i.e. RESET_HOLD+1 locked edges in total.
  always_ff @(posedge i_clk_25mhz) begin
    if (i_reset || !i_locked) begin
      r_cnt        <= CW'(RESET_HOLD);
      r_core_reset <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt        <= r_cnt - CW'(1);
      r_core_reset <= 1'b1;
    end else begin
      r_core_reset <= 1'b0;
    end
  end

  assign o_pix_out    = r_pix2;
  assign o_hsync_out  = r_hs2;
  assign o_vsync_out  = r_vs2;
  assign o_core_reset = r_core_reset;

endmodule

// File: tb/tb_vga_board_adapter.sv
module tb_vga_board_adapter;

  logic        clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst, locked, hs, vs;
  logic [1:0]  mode;
  logic [23:0] pix;

  logic        hs_o, vs_o, cr;
  logic [11:0] pix_o;
  logic        hs_t, vs_t, cr_t;
  logic [11:0] pix_t;
  logic        hs_p, vs_p, cr_p;
  logic [23:0] pix_p;

  vga_board_adapter u_dut (
    .i_clk_25mhz(clk), .i_reset(rst), .i_locked(locked), .i_mode(mode),
    .i_hsync_in(hs), .i_vsync_in(vs), .i_pix_in(pix),
    .o_hsync_out(hs_o), .o_vsync_out(vs_o), .o_pix_out(pix_o), .o_core_reset(cr)
  );

  vga_board_adapter #(.TEMPORAL(1)) u_tmp (
    .i_clk_25mhz(clk), .i_reset(rst), .i_locked(locked), .i_mode(mode),
    .i_hsync_in(hs), .i_vsync_in(vs), .i_pix_in(pix),
    .o_hsync_out(hs_t), .o_vsync_out(vs_t), .o_pix_out(pix_t), .o_core_reset(cr_t)
  );

  vga_board_adapter #(.OUT_W(8)) u_pas (
    .i_clk_25mhz(clk), .i_reset(rst), .i_locked(locked), .i_mode(mode),
    .i_hsync_in(hs), .i_vsync_in(vs), .i_pix_in(pix),
    .o_hsync_out(hs_p), .o_vsync_out(vs_p), .o_pix_out(pix_p), .o_core_reset(cr_p)
  );

  typedef struct {
    logic        hs;
    logic        vs;
    logic [1:0]  mode;
    logic [23:0] pix;
    logic [11:0] exp;
    logic [11:0] expt;
  } vec_t;

  vec_t vec[80];
  int   n_vec = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   m4[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
  int   m2[4]  = '{0, 2, 3, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic h, input logic v, input logic [1:0] m,
                     input logic [23:0] p, input logic [11:0] e, input logic [11:0] et);
    vec[n_vec] = '{h, v, m, p, e, et};
    n_vec++;
  endtask

  // Reference reduction for IN_W=8, OUT_W=4: add threshold, saturate, keep MSBs.
  function automatic logic [11:0] red(input logic [23:0] p, input int b);
    logic [11:0] r;
    int s;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = int'(p[c*8 +: 8]) + b;
      if (s > 255) s = 255;
      r[c*4 +: 4] = 4'(s >> 4);
    end
    return r;
  endfunction

  initial begin
    logic h, v;
    int   b, bt;

    // reset state with every input pushing the other way
    rst = 1; locked = 1; hs = 0; vs = 0; mode = 3; pix = 24'hFFFFFF;
    step(); step();
    chk("reset_pix",   32'(pix_o), 32'h000);
    chk("reset_hsync", 32'(hs_o), 32'h1);
    chk("reset_vsync", 32'(vs_o), 32'h1);
    chk("reset_core",  32'(cr), 32'h1);
    chk("reset_core_t", 32'(cr_t), 32'h1);
    chk("reset_pix_p", 32'(pix_p), 32'h0);

    // reset stretcher
    rst = 0; locked = 0; hs = 1; vs = 1; pix = 0; mode = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("unlocked_core", 32'(cr), 32'h1);
    end
    locked = 1;
    for (int j = 1; j <= 17; j++) begin
      step();
      chk($sformatf("stretch_edge%0d", j), 32'(cr), (j < 17) ? 32'h1 : 32'h0);
    end
    locked = 0;
    step();
    chk("lock_drop", 32'(cr), 32'h1);
    locked = 1;
    for (int j = 1; j <= 17; j++) begin
      step();
      chk($sformatf("relock_edge%0d", j), 32'(cr), (j < 17) ? 32'h1 : 32'h0);
      chk("relock_core_p", 32'(cr_p), (j < 17) ? 32'h1 : 32'h0);
    end

    // vector table (syncs active-low)
    add(1, 0, 0, 24'h12AB34, 12'h1A3, 12'h1A3);   // vsync latches truncate
    add(1, 0, 0, 24'hFFFFFF, 12'hFFF, 12'hFFF);
    add(1, 1, 0, 24'h0F0F0F, 12'h000, 12'h000);
    add(1, 1, 1, 24'hA8A8A8, 12'hAAA, 12'hAAA);   // mode changes mid-frame
    add(1, 1, 1, 24'hA8A8A8, 12'hAAA, 12'hAAA);
    add(1, 0, 1, 24'hA8A8A8, 12'hAAA, 12'hAAA);   // vsync pixel: still old mode
    add(1, 0, 1, 24'hA8A7FF, 12'hBAF, 12'hBAF);   // first rounded pixel, FF saturates
    add(1, 1, 1, 24'h000000, 12'h000, 12'h000);
    add(1, 1, 1, 24'h170708, 12'h101, 12'h101);
    add(1, 0, 3, 24'h0, 12'h0, 12'h0);            // extra frame so Bayer frames get f=0,1
    add(1, 1, 3, 24'h0, 12'h0, 12'h0);
    add(1, 1, 3, 24'h0, 12'h0, 12'h0);
    // two Bayer 4x4 frames: f=0 then f=1 (temporal indices x^1, y^2)
    for (int fr = 0; fr < 2; fr++) begin
      add(0, 0, 3, 24'h0, 12'h0, 12'h0);
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          h  = (c == 3 && r < 3) ? 1'b0 : 1'b1;
          v  = (r == 0 && c == 0) ? 1'b0 : 1'b1;
          b  = m4[r*4 + c];
          bt = (fr == 0) ? b : m4[(r ^ 2)*4 + (c ^ 1)];
          add(h, v, 3, 24'h181818, red(24'h181818, b), red(24'h181818, bt));
        end
      end
    end
    // Bayer 2x2 frame, f=2 (temporal flips y[0])
    add(0, 0, 2, 24'h0, 12'h0, 12'h0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        h  = (c == 3 && r == 0) ? 1'b0 : 1'b1;
        v  = (r == 0 && c == 0) ? 1'b0 : 1'b1;
        b  = 4 * m2[(r & 1)*2 + (c & 1)];
        bt = 4 * m2[((r & 1) ^ 1)*2 + (c & 1)];
        add(h, v, 2, 24'h141B1C, red(24'h141B1C, b), red(24'h141B1C, bt));
      end
    end
    add(1, 1, 2, 24'h0, 12'h0, 12'h0);
    add(1, 1, 2, 24'h0, 12'h0, 12'h0);

    for (int i = 0; i < n_vec; i++) begin
      hs = vec[i].hs; vs = vec[i].vs; mode = vec[i].mode; pix = vec[i].pix;
      if (i >= 2) begin
        chk($sformatf("pix[%0d]", i - 2),   32'(pix_o), 32'(vec[i-2].exp));
        chk($sformatf("pix_t[%0d]", i - 2), 32'(pix_t), 32'(vec[i-2].expt));
        chk($sformatf("pix_p[%0d]", i - 2), 32'(pix_p), 32'(vec[i-2].pix));
        chk($sformatf("sync[%0d]", i - 2),  32'({hs_o, vs_o}), 32'({vec[i-2].hs, vec[i-2].vs}));
        chk($sformatf("sync_t[%0d]", i - 2), 32'({hs_t, vs_t, hs_p, vs_p}),
            32'({vec[i-2].hs, vec[i-2].vs, vec[i-2].hs, vec[i-2].vs}));
      end
      step();
    end

    // synchronous reset mid-run: mode back to truncate, counters cleared
    rst = 1; hs = 0; vs = 0; pix = 24'hFFFFFF; mode = 3;
    step();
    chk("midrst_pix",   32'(pix_o), 32'h000);
    chk("midrst_sync",  32'({hs_o, vs_o}), 32'h3);
    chk("midrst_core",  32'(cr), 32'h1);
    rst = 0; hs = 1; vs = 1; pix = 24'h181818;
    step();
    chk("midrst_stage1_clear", 32'(pix_o), 32'h000);
    step();
    chk("midrst_truncate_x1", 32'(pix_o), 32'h111);
    chk("midrst_truncate_x1_t", 32'(pix_t), 32'h111);
    step();
    chk("midrst_truncate_x2", 32'(pix_o), 32'h111);
    chk("midrst_core_hold", 32'(cr), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
